// File: rtl/step_sched_if.sv
// Wishbone slave port bundle for the step_sched stepper-axis scheduler.
interface step_sched_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/step_sched.sv
// Step-timing scheduler for one stepper axis: queued {interval, count, add} moves become step_pulse strobes.
// Define STEP_SCHED_DIR_EN to store bit 31 of word A per move and drive dir; otherwise dir is constant 0.
module step_sched #(
    parameter int QUEUE_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    step_sched_if.slave   bus,
    output logic          step_pulse,
    output logic          dir
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;
    localparam cnt_t FULL_C = cnt_t'(QUEUE_DEPTH);

    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t r_state, w_state_next;

    logic [30:0] r_q_ivl [QUEUE_DEPTH];
    logic [15:0] r_q_cnt [QUEUE_DEPTH];
    logic [15:0] r_q_add [QUEUE_DEPTH];
    ptr_t        r_wr_ptr, r_rd_ptr;
    cnt_t        r_count;

    logic [30:0] r_a_ivl;
    logic [30:0] r_wait, r_ivl;
    logic [15:0] r_rem, r_add;
    logic        r_ovf, r_bad;

    logic        w_cmd, w_wr_a, w_push_req, w_flush, w_clear;
    logic        w_empty, w_full, w_step, w_last, w_pop;
    logic        w_push_ok, w_set_ovf, w_set_bad, w_cnt_zero;
    logic [30:0] w_head_ivl, w_head_wait, w_ivl_sum, w_ivl_upd;

    // Bus decode; flush beats any push arriving in the same cycle.
    assign w_cmd      = bus.wb_cyc_i && bus.wb_stb_i && bus.wb_we_i;
    assign w_wr_a     = w_cmd && (bus.wb_adr_i == 4'd0);
    assign w_push_req = w_cmd && (bus.wb_adr_i == 4'd1);
    assign w_flush    = w_cmd && (bus.wb_adr_i == 4'd2) && bus.wb_dat_i[0];
    assign w_clear    = w_cmd && (bus.wb_adr_i == 4'd2) && bus.wb_dat_i[1];
    assign w_cnt_zero = (bus.wb_dat_i[15:0] == 16'd0);

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_C);
    assign w_step  = (r_state == S_RUN) && (r_wait == 31'd1);
    assign w_last  = w_step && (r_rem == 16'd1);
    assign w_pop   = !w_flush && !w_empty && ((r_state == S_IDLE) || w_last);

    // A pop on the same edge frees the slot a push into a full queue needs.
    assign w_push_ok = w_push_req && !w_flush && !w_cnt_zero && (!w_full || w_pop);
    assign w_set_ovf = w_push_req && !w_flush && !w_cnt_zero && w_full && !w_pop;
    assign w_set_bad = w_push_req && !w_flush && w_cnt_zero;

    assign w_head_ivl  = r_q_ivl[r_rd_ptr];
    assign w_head_wait = (w_head_ivl == 31'd0) ? 31'd1 : w_head_ivl;
    assign w_ivl_sum   = r_ivl + {{15{r_add[15]}}, r_add};
    assign w_ivl_upd   = (w_ivl_sum == 31'd0) ? 31'd1 : w_ivl_sum;

    always_comb begin
        w_state_next = r_state;
        if (w_flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_pop) w_state_next = S_RUN;
                S_RUN:   if (w_last && !w_pop) w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: queue storage is not reset; a slot is only read after it has been written, so clearing the pointers is enough.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_q_ivl[r_wr_ptr] <= r_a_ivl;
            r_q_cnt[r_wr_ptr] <= bus.wb_dat_i[15:0];
            r_q_add[r_wr_ptr] <= bus.wb_dat_i[31:16];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + ptr_t'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + ptr_t'(1);
            r_count <= r_count + cnt_t'(w_push_ok) - cnt_t'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_ivl <= '0;
            r_ovf   <= 1'b0;
            r_bad   <= 1'b0;
        end else begin
            if (w_wr_a) r_a_ivl <= bus.wb_dat_i[30:0];
            r_ovf <= (r_ovf && !w_clear) || w_set_ovf;
            r_bad <= (r_bad && !w_clear) || w_set_bad;
        end
    end

    // A move's last step pops the next move on the same edge, so no gap and no carried-over add.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait     <= '0;
            r_ivl      <= '0;
            r_rem      <= '0;
            r_add      <= '0;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= w_step && !w_flush;
            if (w_pop) begin
                r_wait <= w_head_wait;
                r_ivl  <= w_head_wait;
                r_rem  <= r_q_cnt[r_rd_ptr];
                r_add  <= r_q_add[r_rd_ptr];
            end else if (w_step) begin
                r_rem  <= r_rem - 16'd1;
                r_ivl  <= w_ivl_upd;
                r_wait <= w_ivl_upd;
            end else if (r_state == S_RUN) begin
                r_wait <= r_wait - 31'd1;
            end
        end
    end

`ifdef STEP_SCHED_DIR_EN
    logic r_q_dir [QUEUE_DEPTH];
    logic r_a_dir;
    logic r_dir;

    always_ff @(posedge clk) begin
        if (w_push_ok) r_q_dir[r_wr_ptr] <= r_a_dir;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_dir <= 1'b0;
            r_dir   <= 1'b0;
        end else begin
            if (w_wr_a) r_a_dir <= bus.wb_dat_i[31];
            if (w_pop)  r_dir   <= r_q_dir[r_rd_ptr];
        end
    end

    assign dir = r_dir;
`else
    assign dir = 1'b0;
`endif

    always_comb begin
        bus.wb_dat_o = '0;
        if (bus.wb_adr_i == 4'd3) begin
            bus.wb_dat_o[7:0] = 8'(r_count);
            bus.wb_dat_o[8]   = (r_state == S_RUN);
            bus.wb_dat_o[9]   = r_ovf;
            bus.wb_dat_o[10]  = r_bad;
        end
    end

    assign bus.wb_ack_o = 1'b1;
endmodule

// File: tb/tb_step_sched.sv
// Directed bench for step_sched: vector table of single moves plus hand-written queue, flush, dir and reset sequences.
module tb_step_sched;
    localparam int DEPTH = 4;
`ifdef STEP_SCHED_DIR_EN
    localparam logic DIR_EN = 1'b1;
`else
    localparam logic DIR_EN = 1'b0;
`endif

    typedef struct {
        logic [30:0] ivl;
        logic [15:0] cnt;
        logic [15:0] add;
        int          n;
        int          e0, e1, e2, e3;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic step_pulse, dir;

    step_sched_if bus();

    step_sched #(.QUEUE_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .step_pulse (step_pulse),
        .dir        (dir)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Pulse high in the cycle that begins at edge n is logged as n.
    int pulses[$];
    always @(negedge clk) if (step_pulse === 1'b1) pulses.push_back(cyc_cnt);

    int n_checks = 0;
    int n_fail   = 0;
    int w_edge;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wb_write(input logic [3:0] adr, input logic [31:0] dat);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b1;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        @(posedge clk);
        #1;
        w_edge = cyc_cnt;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        @(negedge clk);
    endtask

    task automatic wb_read(input logic [3:0] adr, output logic [31:0] dat);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = adr;
        #1;
        dat = bus.wb_dat_o;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
    endtask

    task automatic push(input logic [30:0] ivl, input logic dbit, input logic [15:0] cnt, input logic [15:0] add);
        wb_write(4'd0, {dbit, ivl});
        wb_write(4'd1, {add, cnt});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_status(input string name, input int entries, input logic running,
                                input logic ovf, input logic bad);
        logic [31:0] s;
        wb_read(4'd3, s);
        check({name, "_status"}, s, {21'd0, bad, ovf, running, 8'(entries)});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;
        int p, last;
        int e [4];

        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = '0;
        bus.wb_dat_i = '0;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;

        check("reset_step_pulse", {31'd0, step_pulse}, 32'd0);
        check("reset_dir", {31'd0, dir}, 32'd0);
        check("reset_ack", {31'd0, bus.wb_ack_o}, 32'd1);
        check_status("reset", 0, 1'b0, 1'b0, 1'b0);

        vecs[0] = '{31'd10, 16'd3, 16'h0000, 3, 10, 20, 30, 0};
        vecs[1] = '{31'd0,  16'd2, 16'h0000, 2, 1, 2, 0, 0};
        vecs[2] = '{31'd1,  16'd3, 16'h0000, 3, 1, 2, 3, 0};
        vecs[3] = '{31'd3,  16'd3, 16'hFFFF, 3, 3, 5, 6, 0};
        vecs[4] = '{31'd2,  16'd2, 16'hFFFE, 2, 2, 3, 0, 0};
        vecs[5] = '{31'd5,  16'd2, 16'h0003, 2, 5, 13, 0, 0};

        for (int i = 0; i < 6; i++) begin
            pulses.delete();
            push(vecs[i].ivl, 1'b0, vecs[i].cnt, vecs[i].add);
            p = w_edge + 1;
            check_status($sformatf("vec%0d_queued", i), 1, 1'b0, 1'b0, 1'b0);
            e = '{vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3};
            last = e[vecs[i].n - 1];
            idle(last + 20);
            check($sformatf("vec%0d_npulses", i), pulses.size(), vecs[i].n);
            for (int j = 0; j < vecs[i].n; j++)
                if (j < pulses.size())
                    check($sformatf("vec%0d_pulse%0d_offset", i, j), pulses[j] - p, e[j]);
            check_status($sformatf("vec%0d_done", i), 0, 1'b0, 1'b0, 1'b0);
        end

        // Decreasing interval, then a queued move that follows the last step with no gap.
        pulses.delete();
        push(31'd100, 1'b0, 16'd4, 16'hFFF6);
        p = w_edge + 1;
        idle(10);
        push(31'd5, 1'b0, 16'd1, 16'h0000);
        check_status("chain_queued", 1, 1'b1, 1'b0, 1'b0);
        idle(360);
        check("chain_npulses", pulses.size(), 5);
        e = '{100, 190, 270, 340};
        for (int j = 0; j < 4; j++)
            if (j < pulses.size()) check($sformatf("chain_pulse%0d", j), pulses[j] - p, e[j]);
        if (pulses.size() > 4) check("chain_pulse4", pulses[4] - p, 345);
        check_status("chain_done", 0, 1'b0, 1'b0, 1'b0);

        // Full queue: push coinciding with a pop is accepted, the next one overflows.
        pulses.delete();
        push(31'd30, 1'b0, 16'd1, 16'h0000);
        p = w_edge + 1;
        for (int k = 0; k < DEPTH; k++) push(31'd1000, 1'b0, 16'd1, 16'h0000);
        check_status("fill_full", DEPTH, 1'b1, 1'b0, 1'b0);
        idle(p + 28 - cyc_cnt);
        push(31'd7, 1'b0, 16'd1, 16'h0000);
        check("pop_push_edge", w_edge - p, 30);
        idle(1);
        check("pop_push_npulses", pulses.size(), 1);
        if (pulses.size() > 0) check("pop_push_pulse", pulses[0] - p, 30);
        check_status("pop_push_accepted", DEPTH, 1'b1, 1'b0, 1'b0);
        push(31'd7, 1'b0, 16'd1, 16'h0000);
        check_status("overflow_set", DEPTH, 1'b1, 1'b1, 1'b0);
        wb_read(4'd0, s);
        check("read_other_addr", s, 32'd0);
        wb_write(4'd2, 32'd2);
        check_status("overflow_clear", DEPTH, 1'b1, 1'b0, 1'b0);
        wb_write(4'd2, 32'd1);
        check_status("flush_full", 0, 1'b0, 1'b0, 1'b0);

        push(31'd5, 1'b0, 16'd0, 16'h0000);
        check_status("bad_count_set", 0, 1'b0, 1'b0, 1'b1);
        wb_write(4'd2, 32'd2);
        check_status("bad_count_clear", 0, 1'b0, 1'b0, 1'b0);

        // Flush one cycle before a step, with another move queued.
        pulses.delete();
        push(31'd20, 1'b0, 16'd1, 16'h0000);
        p = w_edge + 1;
        push(31'd5, 1'b0, 16'd1, 16'h0000);
        idle(p + 18 - cyc_cnt);
        wb_write(4'd2, 32'd1);
        idle(40);
        check("flush_early_npulses", pulses.size(), 0);
        check_status("flush_early", 0, 1'b0, 1'b0, 1'b0);

        // Flush on the step edge itself suppresses that pulse.
        pulses.delete();
        push(31'd20, 1'b0, 16'd2, 16'h0000);
        p = w_edge + 1;
        idle(p + 19 - cyc_cnt);
        wb_write(4'd2, 32'd1);
        check("flush_on_step_edge", w_edge - p, 20);
        idle(40);
        check("flush_on_step_npulses", pulses.size(), 0);
        check_status("flush_on_step", 0, 1'b0, 1'b0, 1'b0);

        // Direction follows each move's pop edge.
        push(31'd20, 1'b1, 16'd1, 16'h0000);
        p = w_edge + 1;
        check("dir_before_pop", {31'd0, dir}, 32'd0);
        push(31'd20, 1'b0, 16'd1, 16'h0000);
        check("dir_after_pop1", {31'd0, dir}, {31'd0, DIR_EN});
        idle(p + 19 - cyc_cnt);
        check("dir_before_pop2", {31'd0, dir}, {31'd0, DIR_EN});
        idle(1);
        check("dir_after_pop2", {31'd0, dir}, 32'd0);
        idle(30);
        push(31'd10, 1'b1, 16'd5, 16'h0000);
        idle(3);
        wb_write(4'd2, 32'd1);
        check("dir_kept_on_flush", {31'd0, dir}, {31'd0, DIR_EN});

        // Reset mid-move clears everything including dir and staged word A.
        pulses.delete();
        push(31'd10, 1'b1, 16'd5, 16'h0000);
        idle(3);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("rst_dir", {31'd0, dir}, 32'd0);
        check_status("rst_mid_move", 0, 1'b0, 1'b0, 1'b0);
        idle(60);
        check("rst_npulses", pulses.size(), 0);
        wb_write(4'd1, 32'd1);
        p = w_edge + 1;
        idle(5);
        check("rst_word_a_npulses", pulses.size(), 1);
        if (pulses.size() > 0) check("rst_word_a_pulse", pulses[0] - p, 1);
        check("rst_word_a_dir", {31'd0, dir}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
